// File: rtl/debug_view_if.sv
// Handshake bundle between the debug-display controller and its surroundings:
// raw buttons, auto-rotate level and live data in; mode, data and status out.
interface debug_view_if;
  logic        btn_mode;
  logic        btn_hold;
  logic        auto_en;
  logic [31:0] disp_data_in;
  logic [1:0]  mode;
  logic [31:0] disp_data;
  logic        hold_active;
  logic        mode_step;

  modport master (
    output btn_mode, btn_hold, auto_en, disp_data_in,
    input  mode, disp_data, hold_active, mode_step
  );

  modport slave (
    input  btn_mode, btn_hold, auto_en, disp_data_in,
    output mode, disp_data, hold_active, mode_step
  );
endinterface

// File: rtl/debug_view_ctrl.sv
// Debug display sequencer: debounced mode/hold buttons, 2-bit mode stepping
// (manual or auto-rotate) and a live/frozen snapshot of the CPU debug word.
module debug_view_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_PERIOD     = 32
) (
  input  logic         clk,
  input  logic         rst,
  debug_view_if.slave  dv
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int AP_W = $clog2(AUTO_PERIOD);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AP_W-1:0] AP_LAST = AP_W'(AUTO_PERIOD - 1);

  localparam logic [0:0] ST_LIVE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  // Index 0 is the mode button, index 1 the hold button.
  logic [1:0] btn_raw;
  logic [1:0] press_pulse;

  assign btn_raw = {dv.btn_hold, dv.btn_mode};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            stable_reg;
      logic            press_reg;
      logic [DB_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          stable_reg <= 1'b0;
          press_reg  <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            // Only a rising accepted level is a press; release is silent.
            stable_reg <= sync2_reg;
            press_reg  <= sync2_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + DB_W'(1);
          end
        end
      end

      assign press_pulse[gi] = press_reg;
    end
  endgenerate

  logic [AP_W-1:0] auto_cnt_reg;
  logic [1:0]      mode_reg;
  logic            mode_step_reg;
  logic            auto_fire;
  logic            step;

  assign auto_fire = dv.auto_en && (auto_cnt_reg == AP_LAST);
  // A press coinciding with auto expiry still yields a single step.
  assign step      = press_pulse[0] || auto_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg      <= 2'b00;
      mode_step_reg <= 1'b0;
      auto_cnt_reg  <= '0;
    end else begin
      mode_step_reg <= step;
      if (step) begin
        mode_reg <= mode_reg + 2'd1;
      end
      if (press_pulse[0] || !dv.auto_en || auto_fire) begin
        auto_cnt_reg <= '0;
      end else begin
        auto_cnt_reg <= auto_cnt_reg + AP_W'(1);
      end
    end
  end

  logic [0:0]  state_reg;
  logic [31:0] disp_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_LIVE;
      disp_reg  <= '0;
    end else begin
      case (state_reg)
        ST_LIVE: begin
          // The capture edge still loads, so the frozen word is the one
          // present when the press was accepted.
          disp_reg <= dv.disp_data_in;
          if (press_pulse[1]) begin
            state_reg <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (press_pulse[1]) begin
            state_reg <= ST_LIVE;
          end
        end
        default: state_reg <= ST_LIVE;
      endcase
    end
  end

  assign dv.mode        = mode_reg;
  assign dv.mode_step   = mode_step_reg;
  assign dv.disp_data   = disp_reg;
  assign dv.hold_active = (state_reg == ST_HELD);

endmodule
